// File: rtl/otbn_bignum_mul_seq_if.sv
// Signal bundle between the bignum multiply sequencer, its requester and the MAC.
// The master side is the requester plus the MAC (drives start/operands and the
// MAC result); the slave side is the sequencer.
interface otbn_bignum_mul_seq_if;
  localparam int WLEN = 256;

  logic              start_i;
  logic              abort_i;
  logic [WLEN-1:0]   operand_a_i;
  logic [WLEN-1:0]   operand_b_i;

  logic              mac_en_o;
  logic              mac_commit_o;
  logic [WLEN-1:0]   mac_operand_a_o;
  logic [WLEN-1:0]   mac_operand_b_o;
  logic [1:0]        mac_a_qw_sel_o;
  logic [1:0]        mac_b_qw_sel_o;
  logic [1:0]        mac_pre_acc_shift_o;
  logic              mac_zero_acc_o;
  logic              mac_shift_acc_o;
  logic              mac_predec_op_en_o;
  logic              mac_predec_acc_rd_en_o;
  logic [WLEN-1:0]   mac_result_i;

  logic              busy_o;
  logic              done_o;
  logic [2*WLEN-1:0] result_o;

  modport master (
    output start_i, abort_i, operand_a_i, operand_b_i, mac_result_i,
    input  mac_en_o, mac_commit_o, mac_operand_a_o, mac_operand_b_o,
           mac_a_qw_sel_o, mac_b_qw_sel_o, mac_pre_acc_shift_o,
           mac_zero_acc_o, mac_shift_acc_o, mac_predec_op_en_o,
           mac_predec_acc_rd_en_o, busy_o, done_o, result_o
  );

  modport slave (
    input  start_i, abort_i, operand_a_i, operand_b_i, mac_result_i,
    output mac_en_o, mac_commit_o, mac_operand_a_o, mac_operand_b_o,
           mac_a_qw_sel_o, mac_b_qw_sel_o, mac_pre_acc_shift_o,
           mac_zero_acc_o, mac_shift_acc_o, mac_predec_op_en_o,
           mac_predec_acc_rd_en_o, busy_o, done_o, result_o
  );
endinterface

// File: rtl/otbn_bignum_mul_seq.sv
// Full 256x256 -> 512 multiply sequencer. Drives the bignum MAC through the
// 16 quarter-word MULQACC ops (one per cycle) and assembles the 512-bit
// product from the 128-bit half-words the MAC shifts out.
module otbn_bignum_mul_seq (
  input  logic                 clk_i,
  input  logic                 rst_i,
  otbn_bignum_mul_seq_if.slave bus
);
  localparam int WLEN  = 256;
  localparam int HWLEN = WLEN / 2;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [3:0]        idx_q, idx_d;
  logic [WLEN-1:0]   opa_q, opa_d;
  logic [WLEN-1:0]   opb_q, opb_d;
  logic [2*WLEN-1:0] res_q, res_d;
  logic              done_q, done_d;

  logic [1:0]        a_qw, b_qw, pre_sh;
  logic              zero_acc, shift_acc;
  logic              run, mac_en;

  // Only the low half-word of the MAC result is ever collected.
  logic unused_res_hi;
  assign unused_res_hi = ^bus.mac_result_i[WLEN-1:HWLEN];

  // Op schedule: column-ordered quarter-word products so that each finished
  // 128-bit column can be shifted out of the accumulator.
  always_comb begin
    {a_qw, b_qw, pre_sh} = 6'd0;
    case (idx_q)
      4'd0:    {a_qw, b_qw, pre_sh} = {2'd0, 2'd0, 2'd0};
      4'd1:    {a_qw, b_qw, pre_sh} = {2'd0, 2'd1, 2'd1};
      4'd2:    {a_qw, b_qw, pre_sh} = {2'd1, 2'd0, 2'd1};
      4'd3:    {a_qw, b_qw, pre_sh} = {2'd0, 2'd2, 2'd0};
      4'd4:    {a_qw, b_qw, pre_sh} = {2'd1, 2'd1, 2'd0};
      4'd5:    {a_qw, b_qw, pre_sh} = {2'd2, 2'd0, 2'd0};
      4'd6:    {a_qw, b_qw, pre_sh} = {2'd0, 2'd3, 2'd1};
      4'd7:    {a_qw, b_qw, pre_sh} = {2'd1, 2'd2, 2'd1};
      4'd8:    {a_qw, b_qw, pre_sh} = {2'd2, 2'd1, 2'd1};
      4'd9:    {a_qw, b_qw, pre_sh} = {2'd3, 2'd0, 2'd1};
      4'd10:   {a_qw, b_qw, pre_sh} = {2'd1, 2'd3, 2'd0};
      4'd11:   {a_qw, b_qw, pre_sh} = {2'd2, 2'd2, 2'd0};
      4'd12:   {a_qw, b_qw, pre_sh} = {2'd3, 2'd1, 2'd0};
      4'd13:   {a_qw, b_qw, pre_sh} = {2'd2, 2'd3, 2'd1};
      4'd14:   {a_qw, b_qw, pre_sh} = {2'd3, 2'd2, 2'd1};
      default: {a_qw, b_qw, pre_sh} = {2'd3, 2'd3, 2'd0};
    endcase
    zero_acc  = (idx_q == 4'd0);
    shift_acc = (idx_q == 4'd2) || (idx_q == 4'd9) || (idx_q == 4'd14);
  end

  // Next-state, operand latch, result capture and MAC enable.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    res_d   = res_q;
    done_d  = 1'b0;
    mac_en  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start_i) begin
          state_d = RUN;
          idx_d   = 4'd0;
          opa_d   = bus.operand_a_i;
          opb_d   = bus.operand_b_i;
          res_d   = '0;
        end
      end
      RUN: begin
        if (bus.abort_i) begin
          // Gate the op in flight so the MAC never commits it.
          state_d = IDLE;
          idx_d   = 4'd0;
          res_d   = '0;
        end else begin
          mac_en = 1'b1;
          case (idx_q)
            4'd2:    res_d[0*HWLEN +: HWLEN] = bus.mac_result_i[HWLEN-1:0];
            4'd9:    res_d[1*HWLEN +: HWLEN] = bus.mac_result_i[HWLEN-1:0];
            4'd14:   res_d[2*HWLEN +: HWLEN] = bus.mac_result_i[HWLEN-1:0];
            4'd15:   res_d[3*HWLEN +: HWLEN] = bus.mac_result_i[HWLEN-1:0];
            default: ;
          endcase
          if (idx_q == 4'd15) begin
            state_d = IDLE;
            idx_d   = 4'd0;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counter, operand and result registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      idx_q   <= 4'd0;
      opa_q   <= '0;
      opb_q   <= '0;
      res_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      res_q   <= res_d;
      done_q  <= done_d;
    end
  end

  assign run = (state_q == RUN);

  // Control fields are quiet outside RUN; enables additionally drop on abort.
  assign bus.mac_en_o               = mac_en;
  assign bus.mac_commit_o           = mac_en;
  assign bus.mac_operand_a_o        = opa_q;
  assign bus.mac_operand_b_o        = opb_q;
  assign bus.mac_a_qw_sel_o         = run ? a_qw      : 2'd0;
  assign bus.mac_b_qw_sel_o         = run ? b_qw      : 2'd0;
  assign bus.mac_pre_acc_shift_o    = run ? pre_sh    : 2'd0;
  assign bus.mac_zero_acc_o         = run & zero_acc;
  assign bus.mac_shift_acc_o        = run & shift_acc;
  assign bus.mac_predec_op_en_o     = mac_en;
  assign bus.mac_predec_acc_rd_en_o = mac_en & ~(run & zero_acc);

  assign bus.busy_o   = run;
  assign bus.done_o   = done_q;
  assign bus.result_o = res_q;
endmodule

// File: tb/tb_otbn_bignum_mul_seq.sv
// Bench for otbn_bignum_mul_seq: behavioural MAC model drives mac_result_i,
// the product is checked against a plain 512-bit multiply.
module tb_otbn_bignum_mul_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errs = 0;
  int   checks = 0;

  otbn_bignum_mul_seq_if bus ();

  otbn_bignum_mul_seq dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Behavioural bignum MAC: 64x64 quarter-word product, shifted, added to
  // (or replacing) the accumulator; commit optionally shifts right by 128.
  logic [255:0] acc_q = '0;
  logic [255:0] mac_sum;
  logic [63:0]  qa, qb;
  logic [127:0] prod;
  always_comb begin
    qa      = bus.mac_operand_a_o[64*int'(bus.mac_a_qw_sel_o) +: 64];
    qb      = bus.mac_operand_b_o[64*int'(bus.mac_b_qw_sel_o) +: 64];
    prod    = {64'd0, qa} * {64'd0, qb};
    mac_sum = (bus.mac_zero_acc_o ? 256'd0 : acc_q)
            + ({128'd0, prod} << (64*int'(bus.mac_pre_acc_shift_o)));
    bus.mac_result_i = mac_sum;
  end
  always @(posedge clk)
    if (bus.mac_en_o && bus.mac_commit_o)
      acc_q <= bus.mac_shift_acc_o ? (mac_sum >> 128) : mac_sum;

  // Expected op schedule (a_qw, b_qw, pre_acc_shift).
  int SA[16] = '{0,0,1,0,1,2,0,1,2,3,1,2,3,2,3,3};
  int SB[16] = '{0,1,0,2,1,0,3,2,1,0,3,2,1,3,2,3};
  int SS[16] = '{0,1,1,0,0,0,1,1,1,1,0,0,0,1,1,0};

  function automatic logic [511:0] ref_mul(input logic [255:0] a, input logic [255:0] b);
    logic [511:0] x, y;
    x = {256'd0, a};
    y = {256'd0, b};
    return x * y;
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] ctrl_now();
    return {bus.mac_a_qw_sel_o, bus.mac_b_qw_sel_o, bus.mac_pre_acc_shift_o,
            bus.mac_zero_acc_o, bus.mac_shift_acc_o};
  endfunction

  function automatic logic [3:0] en_now();
    return {bus.mac_en_o, bus.mac_commit_o, bus.mac_predec_op_en_o, bus.mac_predec_acc_rd_en_o};
  endfunction

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"}, bus.busy_o, 1'b0);
    chk({tag, "_en"},   en_now(), 4'd0);
    chk({tag, "_ctrl"}, ctrl_now(), 8'd0);
  endtask

  // Starts a multiply at the current negedge, checks every op cycle, and
  // returns at the negedge of the done cycle (cycle 17). restart_cyc != 0
  // pulses start with other operands in that cycle.
  task automatic do_mul(input logic [255:0] a, input logic [255:0] b, input int restart_cyc);
    logic [7:0] ec;
    bus.start_i = 1'b1;
    bus.operand_a_i = a;
    bus.operand_b_i = b;
    @(negedge clk);
    bus.start_i = 1'b0;
    chk("res_clr_on_start", bus.result_o, '0);
    for (int c = 1; c <= 16; c++) begin
      int k;
      k  = c - 1;
      ec = {SA[k][1:0], SB[k][1:0], SS[k][1:0], 1'(k == 0), 1'(k == 2 || k == 9 || k == 14)};
      chk("run_busy", bus.busy_o, 1'b1);
      chk("run_done", bus.done_o, 1'b0);
      chk("run_en",   en_now(), {3'b111, 1'(k != 0)});
      chk("run_ctrl", ctrl_now(), ec);
      chk("run_opa",  bus.mac_operand_a_o, a);
      chk("run_opb",  bus.mac_operand_b_o, b);
      if (c == restart_cyc) begin
        bus.start_i = 1'b1;
        bus.operand_a_i = ~a;
        bus.operand_b_i = ~b;
      end
      @(negedge clk);
      bus.start_i = 1'b0;
    end
    chk("done_pulse", bus.done_o, 1'b1);
    chk("done_busy",  bus.busy_o, 1'b0);
    chk("done_en",    en_now(), 4'd0);
    chk("product",    bus.result_o, ref_mul(a, b));
  endtask

  initial begin
    logic [255:0] a, b;
    logic [511:0] held;
    bus.start_i = 1'b0;
    bus.abort_i = 1'b0;
    bus.operand_a_i = '0;
    bus.operand_b_i = '0;

    // Reset, with start held high to confirm reset wins.
    bus.start_i = 1'b1;
    repeat (2) @(negedge clk);
    chk_idle("rst");
    chk("rst_done", bus.done_o, 1'b0);
    chk("rst_res",  bus.result_o, '0);
    chk("rst_opa",  bus.mac_operand_a_o, '0);
    chk("rst_opb",  bus.mac_operand_b_o, '0);
    bus.start_i = 1'b0;
    rst = 1'b0;
    @(negedge clk);

    // 1 x 1, then result holds and done drops.
    do_mul(256'd1, 256'd1, 0);
    chk("one_val", bus.result_o, 512'd1);
    @(negedge clk);
    chk("one_done_drop", bus.done_o, 1'b0);
    chk("one_hold", bus.result_o, 512'd1);
    chk_idle("one_after");

    // All ones squared.
    do_mul({256{1'b1}}, {256{1'b1}}, 0);
    chk("ones_hi", bus.result_o[511:256], {{255{1'b1}}, 1'b0});
    chk("ones_lo", bus.result_o[255:0], 256'd1);
    @(negedge clk);

    // 2^255 * 2 = 2^256, then chain straight into random vectors on the done cycle.
    a = '0; a[255] = 1'b1;
    do_mul(a, 256'd2, 0);
    held = '0; held[256] = 1'b1;
    chk("pow_val", bus.result_o, held);
    for (int v = 0; v < 1000; v++) begin
      a = rand256();
      b = rand256();
      if ($urandom_range(0, 15) == 0) a = {256{1'b1}};
      if ($urandom_range(0, 15) == 0) b = {192'd0, a[63:0]};
      do_mul(a, b, 0);
    end
    @(negedge clk);
    chk("chain_done_drop", bus.done_o, 1'b0);

    // Start during RUN is ignored.
    a = rand256();
    b = rand256();
    do_mul(a, b, 8);
    @(negedge clk);
    chk("restart_ignored_busy", bus.busy_o, 1'b0);
    chk("restart_ignored_done", bus.done_o, 1'b0);

    // Abort in cycle 5.
    bus.start_i = 1'b1;
    bus.operand_a_i = rand256();
    bus.operand_b_i = rand256();
    @(negedge clk);
    bus.start_i = 1'b0;
    repeat (4) @(negedge clk);
    bus.abort_i = 1'b1;
    #1;
    chk("abort_en_gate", en_now(), 4'd0);
    chk("abort_busy_c5", bus.busy_o, 1'b1);
    @(negedge clk);
    bus.abort_i = 1'b0;
    chk("abort_busy_c6", bus.busy_o, 1'b0);
    chk("abort_res", bus.result_o, '0);
    chk("abort_done_c6", bus.done_o, 1'b0);
    @(negedge clk);
    chk("abort_done_c7", bus.done_o, 1'b0);
    chk_idle("abort_idle");
    // Abort in IDLE is inert.
    bus.abort_i = 1'b1;
    @(negedge clk);
    bus.abort_i = 1'b0;
    chk_idle("abort_in_idle");
    a = rand256();
    b = rand256();
    do_mul(a, b, 0);
    @(negedge clk);

    // Reset in cycle 10.
    bus.start_i = 1'b1;
    bus.operand_a_i = rand256();
    bus.operand_b_i = rand256();
    @(negedge clk);
    bus.start_i = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_idle("mid_rst");
    chk("mid_rst_done", bus.done_o, 1'b0);
    chk("mid_rst_res",  bus.result_o, '0);
    chk("mid_rst_opa",  bus.mac_operand_a_o, '0);
    rst = 1'b0;
    @(negedge clk);
    a = rand256();
    b = rand256();
    do_mul(a, b, 0);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
